// File: rtl/roi_crop_pkg.sv
// Shared Hough-pipeline globals and the crop stage state type.
package roi_crop_pkg;

   localparam int unsigned WIDTH          = 8;
   localparam int unsigned HEIGHT         = 6;
   localparam int unsigned STARTING_X     = 2;
   localparam int unsigned STARTING_Y     = 1;
   localparam int unsigned REDUCED_WIDTH  = 4;
   localparam int unsigned REDUCED_HEIGHT = 3;

   typedef enum logic [0:0] {
      STREAM = 1'b0,
      DONE   = 1'b1
   } crop_state_t;

endpackage

// File: rtl/roi_crop_if.sv
// FIFO-facing signals of the crop stage: upstream FWFT read side and
// downstream write side.
interface roi_crop_if;

   logic       in_rd_en;
   logic       in_empty;
   logic [7:0] in_dout;
   logic       out_wr_en;
   logic       out_full;
   logic [7:0] out_din;

   modport master (
      output in_rd_en,
      input  in_empty,
      input  in_dout,
      output out_wr_en,
      input  out_full,
      output out_din
   );

   modport slave (
      input  in_rd_en,
      output in_empty,
      output in_dout,
      input  out_wr_en,
      output out_full,
      input  out_din
   );

endinterface

// File: rtl/roi_crop.sv
// Region-of-interest crop: streams a full raster frame from the upstream
// FIFO and forwards only the configured window into the reduced-image FIFO.
module roi_crop #(
   parameter int unsigned WIDTH   = roi_crop_pkg::WIDTH,
   parameter int unsigned HEIGHT  = roi_crop_pkg::HEIGHT,
   parameter int unsigned START_X = roi_crop_pkg::STARTING_X,
   parameter int unsigned START_Y = roi_crop_pkg::STARTING_Y,
   parameter int unsigned CROP_W  = roi_crop_pkg::REDUCED_WIDTH,
   parameter int unsigned CROP_H  = roi_crop_pkg::REDUCED_HEIGHT
) (
   input  logic          clock,
   input  logic          reset,
   roi_crop_if.master    bus,
   output logic          frame_done
);

   import roi_crop_pkg::*;

   localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
   localparam logic [XW-1:0] X_LO   = XW'(START_X);
   localparam logic [YW-1:0] Y_LO   = YW'(START_Y);
   // Inclusive upper bounds: START+CROP can equal the frame size and would
   // not fit in the counter width, START+CROP-1 always does.
   localparam logic [XW-1:0] X_HI   = XW'(START_X + CROP_W - 1);
   localparam logic [YW-1:0] Y_HI   = YW'(START_Y + CROP_H - 1);

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          buf_valid;
   logic [7:0]    buf_data;
   logic          buf_last;
   crop_state_t   state;

   logic          rd;
   logic          wr;
   logic          inwin;
   logic          at_last;

   // Handshake decode and window membership of the current head pixel.
   always_comb begin
      wr      = buf_valid && !bus.out_full;
      rd      = !reset && !bus.in_empty && (!buf_valid || wr);
      // Signed compares with a zero-extended operand keep the edge-window
      // cases (bound 0 or frame size-1) from folding to constants.
      inwin   = ($signed({1'b0, x}) >= $signed({1'b0, X_LO})) &&
                ($signed({1'b0, x}) <= $signed({1'b0, X_HI})) &&
                ($signed({1'b0, y}) >= $signed({1'b0, Y_LO})) &&
                ($signed({1'b0, y}) <= $signed({1'b0, Y_HI}));
      at_last = (x == X_HI) && (y == Y_HI);
   end

   assign bus.in_rd_en  = rd;
   assign bus.out_wr_en = wr;
   assign bus.out_din   = wr ? buf_data : '0;
   assign frame_done    = (state == DONE);

   // Raster position counters, advanced on every pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (rd) begin
         if (x == X_LAST) begin
            x <= '0;
            if (y == Y_LAST)
               y <= '0;
            else
               y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   // One-entry output buffer: refilled by in-window pops, freed by pushes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
         buf_last  <= 1'b0;
      end else if (rd && inwin) begin
         buf_valid <= 1'b1;
         buf_data  <= bus.in_dout;
         buf_last  <= at_last;
      end else if (wr) begin
         buf_valid <= 1'b0;
      end
   end

   // Frame-completion FSM: one DONE cycle after the last window pixel leaves.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= STREAM;
      end else begin
         case (state)
            STREAM:  state <= (wr && buf_last) ? DONE : STREAM;
            DONE:    state <= STREAM;
            default: state <= STREAM;
         endcase
      end
   end

endmodule

// File: tb/tb_roi_crop.sv
// Directed bench for roi_crop: a cropped-window instance and a full-frame
// instance share clock, reset and flow-control stimulus.
module tb_roi_crop;

   import roi_crop_pkg::*;

   localparam int unsigned B_W  = 8;
   localparam int unsigned B_H  = 6;
   localparam int unsigned B_SX = 2;
   localparam int unsigned B_SY = 1;
   localparam int unsigned B_CW = 4;
   localparam int unsigned B_CH = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        empty_force = 1'b0;
   logic        full_force  = 1'b0;
   int unsigned feed_limit  = 0;

   int unsigned nvec  = 0;
   int unsigned nfail = 0;

   roi_crop_if r_if ();
   roi_crop_if f_if ();
   logic fd_w [2];

   int unsigned rd_idx [2] = '{0, 0};

   assign r_if.in_empty = empty_force || (rd_idx[0] >= feed_limit);
   assign r_if.in_dout  = 8'(rd_idx[0] % 48);
   assign r_if.out_full = full_force;
   assign f_if.in_empty = empty_force || (rd_idx[1] >= feed_limit);
   assign f_if.in_dout  = 8'(rd_idx[1] % 48);
   assign f_if.out_full = full_force;

   roi_crop #(
      .WIDTH   (B_W),
      .HEIGHT  (B_H),
      .START_X (B_SX),
      .START_Y (B_SY),
      .CROP_W  (B_CW),
      .CROP_H  (B_CH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (r_if),
      .frame_done (fd_w[0])
   );

   roi_crop #(
      .WIDTH   (8),
      .HEIGHT  (6),
      .START_X (0),
      .START_Y (0),
      .CROP_W  (8),
      .CROP_H  (6)
   ) dut_ff (
      .clock      (clock),
      .reset      (reset),
      .bus        (f_if),
      .frame_done (fd_w[1])
   );

   initial begin
      assert (B_SX + B_CW <= B_W && B_SY + B_CH <= B_H && B_CW >= 1 && B_CH >= 1)
         else $fatal(1, "FAIL config: illegal crop window");
   end

   logic       rd_w  [2];
   logic       wr_w  [2];
   logic       ful_w [2];
   logic [7:0] din_w [2];
   assign rd_w[0]  = r_if.in_rd_en;
   assign wr_w[0]  = r_if.out_wr_en;
   assign ful_w[0] = r_if.out_full;
   assign din_w[0] = r_if.out_din;
   assign rd_w[1]  = f_if.in_rd_en;
   assign wr_w[1]  = f_if.out_wr_en;
   assign ful_w[1] = f_if.out_full;
   assign din_w[1] = f_if.out_din;

   int unsigned cyc = 0;
   int unsigned wn  [2] = '{0, 0};
   int unsigned dn  [2] = '{0, 0};
   int unsigned bad [2] = '{0, 0};
   logic [7:0]  wval [2][256];
   int unsigned wcyc [2][256];
   int unsigned dcyc [2][8];

   // Upstream FIFO model and downstream write/frame_done recorder.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            rd_idx[i] <= 0;
            wn[i]     <= 0;
            dn[i]     <= 0;
            bad[i]    <= 0;
         end else begin
            if (rd_w[i])
               rd_idx[i] <= rd_idx[i] + 1;
            if (wr_w[i]) begin
               if (wn[i] < 256) begin
                  wval[i][wn[i][7:0]] <= din_w[i];
                  wcyc[i][wn[i][7:0]] <= cyc;
               end
               wn[i] <= wn[i] + 1;
            end
            if ((!wr_w[i] && din_w[i] != 8'h00) || (wr_w[i] && ful_w[i]))
               bad[i] <= bad[i] + 1;
            if (fd_w[i]) begin
               if (dn[i] < 8)
                  dcyc[i][dn[i][2:0]] <= cyc;
               dn[i] <= dn[i] + 1;
            end
         end
      end
   end

   logic [7:0] exp_win [12] = '{8'd10, 8'd11, 8'd12, 8'd13,
                                8'd18, 8'd19, 8'd20, 8'd21,
                                8'd26, 8'd27, 8'd28, 8'd29};

   task automatic do_reset;
      reset       = 1'b1;
      empty_force = 1'b0;
      full_force  = 1'b0;
      feed_limit  = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_fed(input int unsigned budget);
      int unsigned n;
      n = 0;
      while ((rd_idx[0] < feed_limit || rd_idx[1] < feed_limit) && n < budget) begin
         @(negedge clock);
         n++;
      end
      repeat (6) @(negedge clock);
   endtask

   task automatic test_reset;
      reset       = 1'b1;
      empty_force = 1'b0;
      full_force  = 1'b0;
      feed_limit  = 1000;
      @(negedge clock);
      nvec++;
      if (r_if.in_rd_en !== 1'b0) begin
         nfail++; $display("FAIL reset_rd_en: got %b expected 0", r_if.in_rd_en);
      end
      nvec++;
      if (r_if.out_wr_en !== 1'b0) begin
         nfail++; $display("FAIL reset_wr_en: got %b expected 0", r_if.out_wr_en);
      end
      nvec++;
      if (r_if.out_din !== 8'h00) begin
         nfail++; $display("FAIL reset_din: got %0d expected 0", r_if.out_din);
      end
      nvec++;
      if (fd_w[0] !== 1'b0) begin
         nfail++; $display("FAIL reset_frame_done: got %b expected 0", fd_w[0]);
      end
      nvec++;
      if (dut.x !== '0 || dut.y !== '0) begin
         nfail++; $display("FAIL reset_counters: got (%0d,%0d) expected (0,0)", dut.x, dut.y);
      end
      feed_limit = 0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_free_flow;
      do_reset();
      feed_limit = 48;
      repeat (48) @(negedge clock);
      nvec++;
      if (rd_idx[0] !== 48) begin
         nfail++; $display("FAIL free_reads_48_cycles: got %0d expected 48", rd_idx[0]);
      end
      repeat (6) @(negedge clock);
      nvec++;
      if (wn[0] !== 12) begin
         nfail++; $display("FAIL free_write_count: got %0d expected 12", wn[0]);
      end
      for (int i = 0; i < 12; i++) begin
         nvec++;
         if (wval[0][i] !== exp_win[i]) begin
            nfail++; $display("FAIL free_write[%0d]: got %0d expected %0d", i, wval[0][i], exp_win[i]);
         end
      end
      nvec++;
      if (dn[0] !== 1) begin
         nfail++; $display("FAIL free_done_count: got %0d expected 1", dn[0]);
      end
      nvec++;
      if (dcyc[0][0] !== wcyc[0][11] + 1) begin
         nfail++; $display("FAIL free_done_timing: got cycle %0d expected %0d", dcyc[0][0], wcyc[0][11] + 1);
      end
      nvec++;
      if (bad[0] !== 0) begin
         nfail++; $display("FAIL free_din_hygiene: got %0d violations expected 0", bad[0]);
      end
   endtask

   task automatic test_backpressure;
      int unsigned n;
      do_reset();
      feed_limit = 48;
      n = 0;
      @(negedge clock);
      while (!(r_if.in_rd_en && r_if.in_dout == 8'd11) && n < 100) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      full_force = 1'b1;
      #1;
      nvec++;
      if (r_if.in_rd_en !== 1'b0 || r_if.in_dout !== 8'd12) begin
         nfail++; $display("FAIL bp_stall_start: got rd_en=%b head=%0d expected rd_en=0 head=12", r_if.in_rd_en, r_if.in_dout);
      end
      nvec++;
      if (r_if.out_wr_en !== 1'b0) begin
         nfail++; $display("FAIL bp_no_write_when_full: got %b expected 0", r_if.out_wr_en);
      end
      repeat (9) @(negedge clock);
      nvec++;
      if (rd_idx[0] !== 12 || dut.buf_data !== 8'd11) begin
         nfail++; $display("FAIL bp_held: got reads=%0d buf=%0d expected reads=12 buf=11", rd_idx[0], dut.buf_data);
      end
      full_force = 1'b0;
      wait_fed(200);
      nvec++;
      if (wn[0] !== 12) begin
         nfail++; $display("FAIL bp_write_count: got %0d expected 12", wn[0]);
      end
      for (int i = 0; i < 12; i++) begin
         nvec++;
         if (wval[0][i] !== exp_win[i]) begin
            nfail++; $display("FAIL bp_write[%0d]: got %0d expected %0d", i, wval[0][i], exp_win[i]);
         end
      end
      nvec++;
      if (dn[0] !== 1 || bad[0] !== 0) begin
         nfail++; $display("FAIL bp_done_hygiene: got done=%0d bad=%0d expected done=1 bad=0", dn[0], bad[0]);
      end
   endtask

   task automatic test_starvation;
      int unsigned n;
      do_reset();
      feed_limit = 48;
      n = 0;
      while (rd_idx[0] < feed_limit && n < 400) begin
         @(negedge clock);
         empty_force = ~empty_force;
         n++;
      end
      empty_force = 1'b0;
      repeat (6) @(negedge clock);
      nvec++;
      if (wn[0] !== 12) begin
         nfail++; $display("FAIL starve_write_count: got %0d expected 12", wn[0]);
      end
      for (int i = 0; i < 12; i++) begin
         nvec++;
         if (wval[0][i] !== exp_win[i]) begin
            nfail++; $display("FAIL starve_write[%0d]: got %0d expected %0d", i, wval[0][i], exp_win[i]);
         end
      end
      nvec++;
      if (dut.x !== '0 || dut.y !== '0) begin
         nfail++; $display("FAIL starve_counters: got (%0d,%0d) expected (0,0)", dut.x, dut.y);
      end
      nvec++;
      if (dn[0] !== 1) begin
         nfail++; $display("FAIL starve_done_count: got %0d expected 1", dn[0]);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      feed_limit = 96;
      wait_fed(300);
      nvec++;
      if (wn[0] !== 24) begin
         nfail++; $display("FAIL b2b_write_count: got %0d expected 24", wn[0]);
      end
      for (int i = 0; i < 24; i++) begin
         nvec++;
         if (wval[0][i] !== exp_win[i % 12]) begin
            nfail++; $display("FAIL b2b_write[%0d]: got %0d expected %0d", i, wval[0][i], exp_win[i % 12]);
         end
      end
      nvec++;
      if (dn[0] !== 2) begin
         nfail++; $display("FAIL b2b_done_count: got %0d expected 2", dn[0]);
      end
      nvec++;
      if (dcyc[0][1] !== wcyc[0][23] + 1) begin
         nfail++; $display("FAIL b2b_done2_timing: got cycle %0d expected %0d", dcyc[0][1], wcyc[0][23] + 1);
      end
   endtask

   task automatic test_reset_mid;
      int unsigned n;
      do_reset();
      feed_limit = 48;
      n = 0;
      while (wn[0] < 7 && n < 200) begin
         @(negedge clock);
         n++;
      end
      nvec++;
      if (wval[0][6] !== 8'd20) begin
         nfail++; $display("FAIL mid_last_before_reset: got %0d expected 20", wval[0][6]);
      end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         nvec++;
         if (r_if.out_wr_en !== 1'b0) begin
            nfail++; $display("FAIL mid_no_write_in_reset: got %b expected 0", r_if.out_wr_en);
         end
         @(negedge clock);
      end
      reset = 1'b0;
      wait_fed(200);
      nvec++;
      if (wn[0] !== 12) begin
         nfail++; $display("FAIL mid_write_count: got %0d expected 12", wn[0]);
      end
      for (int i = 0; i < 12; i++) begin
         nvec++;
         if (wval[0][i] !== exp_win[i]) begin
            nfail++; $display("FAIL mid_write[%0d]: got %0d expected %0d", i, wval[0][i], exp_win[i]);
         end
      end
   endtask

   task automatic test_full_frame;
      do_reset();
      feed_limit = 48;
      wait_fed(200);
      nvec++;
      if (wn[1] !== 48) begin
         nfail++; $display("FAIL ff_write_count: got %0d expected 48", wn[1]);
      end
      for (int i = 0; i < 48; i++) begin
         nvec++;
         if (wval[1][i] !== 8'(i)) begin
            nfail++; $display("FAIL ff_write[%0d]: got %0d expected %0d", i, wval[1][i], i);
         end
      end
      nvec++;
      if (dn[1] !== 1) begin
         nfail++; $display("FAIL ff_done_count: got %0d expected 1", dn[1]);
      end
      nvec++;
      if (dcyc[1][0] !== wcyc[1][47] + 1) begin
         nfail++; $display("FAIL ff_done_timing: got cycle %0d expected %0d", dcyc[1][0], wcyc[1][47] + 1);
      end
      nvec++;
      if (bad[1] !== 0) begin
         nfail++; $display("FAIL ff_din_hygiene: got %0d violations expected 0", bad[1]);
      end
   endtask

   initial begin
      test_reset();
      test_free_flow();
      test_backpressure();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
      test_full_frame();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
